// File: rtl/baud_tick_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen_if
//  Brief    : Control/strobe bundle between UART register block and baud timer
//  Revision : 1.0
// ============================================================================
interface baud_tick_gen_if #(
    parameter int DIV_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16
);
    logic                          enable;
    logic                          load;
    logic [DIV_W-1:0]              div_int;
    logic [FRAC_W-1:0]             div_frac;
    logic                          resync;
    logic                          os_tick;
    logic                          mid_tick;
    logic                          bit_tick;
    logic [$clog2(OVERSAMPLE)-1:0] os_phase;
    logic                          cfg_err;

    modport master (
        output enable, load, div_int, div_frac, resync,
        input  os_tick, mid_tick, bit_tick, os_phase, cfg_err
    );

    modport slave (
        input  enable, load, div_int, div_frac, resync,
        output os_tick, mid_tick, bit_tick, os_phase, cfg_err
    );
endinterface
`default_nettype wire

// File: rtl/baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : baud_tick_gen
//  Brief    : Fractional-N UART baud strobe generator (oversample/mid/bit ticks)
//  Revision : 1.0
// ============================================================================
module baud_tick_gen #(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 163
) (
    input  wire logic      clk,
    input  wire logic      rst,
    baud_tick_gen_if.slave bus
);
    localparam int                  c_ph_w     = $clog2(OVERSAMPLE);
    localparam logic [c_ph_w-1:0]   c_mid_idx  = c_ph_w'(OVERSAMPLE / 2 - 1);
    localparam logic [c_ph_w-1:0]   c_last_idx = c_ph_w'(OVERSAMPLE - 1);
    localparam logic [DIV_W:0]      c_one      = (DIV_W + 1)'(1);

    logic [DIV_W-1:0]  r_act_int;
    logic [FRAC_W-1:0] r_act_frac;
    logic [DIV_W-1:0]  r_cnt;
    logic [FRAC_W-1:0] r_acc;
    logic              r_carry;
    logic [c_ph_w-1:0] r_os_cnt;
    logic              r_os_tick;
    logic              r_mid_tick;
    logic              r_bit_tick;
    logic              r_cfg_err;

    logic [DIV_W:0]    w_period;
    logic              w_last;
    logic [FRAC_W:0]   w_frac_sum;
    logic              w_run;

    // Period is one bit wider so act_int = all-ones plus carry cannot wrap.
    assign w_period   = {1'b0, r_act_int} + {{DIV_W{1'b0}}, r_carry};
    assign w_last     = ({1'b0, r_cnt} == (w_period - c_one));
    assign w_frac_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
    assign w_run      = bus.enable && !r_cfg_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_act_int  <= DIV_W'(DEFAULT_DIV);
            r_act_frac <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_os_cnt   <= '0;
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_os_tick  <= 1'b0;
            r_mid_tick <= 1'b0;
            r_bit_tick <= 1'b0;
            if (bus.load) begin
                r_act_int  <= bus.div_int;
                r_act_frac <= bus.div_frac;
                r_cnt      <= '0;
                r_acc      <= '0;
                r_carry    <= 1'b0;
                r_os_cnt   <= '0;
                r_cfg_err  <= (bus.div_int < DIV_W'(2));
            end else if (bus.resync) begin
                r_cnt      <= '0;
                r_acc      <= '0;
                r_carry    <= 1'b0;
                r_os_cnt   <= '0;
            end else if (w_run) begin
                if (w_last) begin
                    // Fraction overflow stretches the next oversample period by one clk.
                    r_cnt               <= '0;
                    {r_carry, r_acc}    <= w_frac_sum;
                    r_os_tick           <= 1'b1;
                    r_mid_tick          <= (r_os_cnt == c_mid_idx);
                    r_bit_tick          <= (r_os_cnt == c_last_idx);
                    r_os_cnt            <= r_os_cnt + 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.os_tick  = r_os_tick;
    assign bus.mid_tick = r_mid_tick;
    assign bus.bit_tick = r_bit_tick;
    assign bus.os_phase = r_os_cnt;
    assign bus.cfg_err  = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_baud_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_baud_tick_gen
//  Brief    : Directed scoreboard bench for baud_tick_gen
//  Revision : 1.0
// ============================================================================
module tb_baud_tick_gen;
    localparam int DIV_W = 16;
    localparam int FRAC_W = 4;
    localparam int OS = 16;

    typedef struct {
        int t;
        int ph;
        bit mid;
        bit bt;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;
    int   os_seen;
    exp_t sb[$];
    int   bit_cyc[$];

    baud_tick_gen_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS)) bus ();

    baud_tick_gen #(
        .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OVERSAMPLE(OS), .DEFAULT_DIV(163)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every os_tick must match the next expected event.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.os_tick) begin
                os_seen++;
                if (bus.bit_tick) bit_cyc.push_back(cyc);
                total++;
                assert (sb.size() != 0)
                else begin
                    bad++;
                    $error("FAIL unexpected_tick cyc=%0d ph=%0d required=no_tick", cyc, bus.os_phase);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    total++;
                    assert (cyc === e.t && int'(bus.os_phase) === e.ph &&
                            bus.mid_tick === e.mid && bus.bit_tick === e.bt)
                    else begin
                        bad++;
                        $error("FAIL os_event observed cyc=%0d ph=%0d mid=%0d bit=%0d required cyc=%0d ph=%0d mid=%0d bit=%0d",
                               cyc, bus.os_phase, bus.mid_tick, bus.bit_tick, e.t, e.ph, e.mid, e.bt);
                    end
                end
            end else begin
                total++;
                assert (!(bus.mid_tick || bus.bit_tick))
                else begin
                    bad++;
                    $error("FAIL stray_tick cyc=%0d mid=%0d bit=%0d required 0 0", cyc, bus.mid_tick, bus.bit_tick);
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int req);
        total++;
        assert (obs === req)
        else begin
            bad++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, req);
        end
    endtask

    // Expected events for a run whose counters were cleared at edge 'start'.
    task automatic push_run(input int start, input int div, input int frac, input int ph0, input int n);
        int   t = start;
        int   ph = ph0;
        int   acc = 0;
        int   carry = 0;
        int   s;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            t     = t + div + carry;
            s     = acc + frac;
            carry = s / (1 << FRAC_W);
            acc   = s % (1 << FRAC_W);
            e.t   = t;
            e.mid = (ph == OS / 2 - 1);
            e.bt  = (ph == OS - 1);
            ph    = (ph + 1) % OS;
            e.ph  = ph;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        assert (sb.size() == 0)
        else begin
            bad++;
            $error("FAIL drain_timeout left=%0d required=0", sb.size());
        end
        sb.delete();
    endtask

    // Returns at the negedge after the load edge; start = that edge index.
    task automatic do_load(input int di, input int df, input bit rs, output int start);
        @(negedge clk);
        bus.load     = 1'b1;
        bus.resync   = rs;
        bus.div_int  = DIV_W'(di);
        bus.div_frac = FRAC_W'(df);
        bus.enable   = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
        bus.resync   = 1'b0;
        start        = cyc;
    endtask

    initial begin
        int st;
        int snap;
        cyc = 0; total = 0; bad = 0; os_seen = 0;
        rst = 1'b1;
        bus.enable = 1'b0; bus.load = 1'b0; bus.resync = 1'b0;
        bus.div_int = '0; bus.div_frac = '0;
        repeat (3) @(negedge clk);
        chk("rst_os_tick", int'(bus.os_tick), 0);
        chk("rst_phase", int'(bus.os_phase), 0);
        chk("rst_cfg_err", int'(bus.cfg_err), 0);
        rst = 1'b0;

        // 1: default divisor
        @(negedge clk);
        chk("idle_mid_bit", int'(bus.mid_tick) + int'(bus.bit_tick), 0);
        bus.enable = 1'b1;
        st = cyc;
        push_run(st, 163, 0, 0, 17);
        drain(3000);
        bus.enable = 1'b0;

        // 2: fractional divisor 10 + 8/16
        do_load(10, 8, 1'b0, st);
        bit_cyc.delete();
        push_run(st, 10, 8, 0, 33);
        drain(500);
        bus.enable = 1'b0;
        chk("frac_cfg_err", int'(bus.cfg_err), 0);
        chk("bit_count", bit_cyc.size(), 2);
        if (bit_cyc.size() >= 2) begin
            chk("first_bit_len", bit_cyc[0] - st, 167);
            chk("bit_period", bit_cyc[1] - bit_cyc[0], 168);
        end

        // 3: illegal divisor stalls, legal one recovers
        do_load(1, 0, 1'b0, st);
        chk("cfg_err_set", int'(bus.cfg_err), 1);
        snap = os_seen;
        repeat (1000) @(negedge clk);
        chk("stall_ticks", os_seen - snap, 0);
        do_load(4, 0, 1'b0, st);
        chk("cfg_err_clr", int'(bus.cfg_err), 0);
        push_run(st, 4, 0, 0, 3);
        drain(50);
        bus.enable = 1'b0;

        // 4: resync mid-period at phase 5
        do_load(10, 0, 1'b0, st);
        push_run(st, 10, 0, 0, 5);
        drain(100);
        chk("pre_resync_phase", int'(bus.os_phase), 5);
        repeat (4) @(negedge clk);
        bus.resync = 1'b1;
        @(negedge clk);
        bus.resync = 1'b0;
        st = cyc;
        push_run(st, 10, 0, 0, 9);
        drain(150);
        bus.enable = 1'b0;

        // 5: enable gap at cnt=3
        do_load(10, 0, 1'b0, st);
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        snap = os_seen;
        repeat (50) @(negedge clk);
        chk("gap_ticks", os_seen - snap, 0);
        bus.enable = 1'b1;
        st = cyc;
        push_run(st - 3, 10, 0, 0, 2);
        drain(50);
        bus.enable = 1'b0;

        // 6: load+resync together, then async reset right after a mid tick
        do_load(20, 0, 1'b1, st);
        push_run(st, 20, 0, 0, 8);
        drain(250);
        chk("pre_rst_mid", int'(bus.mid_tick), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_ticks", int'(bus.os_tick) + int'(bus.mid_tick) + int'(bus.bit_tick), 0);
        chk("async_rst_phase", int'(bus.os_phase), 0);
        chk("async_rst_cfg_err", int'(bus.cfg_err), 0);
        @(negedge clk);
        rst = 1'b0;
        st = cyc;
        push_run(st, 163, 0, 0, 2);
        drain(400);
        bus.enable = 1'b0;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
